ascon_block_packer: RTL
=======================

Name: ascon_block_packer

Overview:
- Upstream feeder for the ASCON-AEAD128 core.
- Accepts a byte stream of associated data (AD) followed by plaintext (PT) and packs it into 128-bit little-endian blocks.
- Applies ASCON 10* padding (0x01 then zeros) to the last block of each segment.
- Presents each block to the core's data_i/data_valid_i with a single-cycle valid pulse, paced by the core's completion strobes (end_init / end_da / end_tc ORed into core_done_i).

Parameters:
BLOCK_BYTES, 16, bytes per block; block width is 8*BLOCK_BYTES. Only 16 is legal for AEAD128.

Ports:
clock_i  in  1  system clock
reset_i  in  1  synchronous, active-high reset
start_i  in  1  one-cycle pulse; begins a new message (AD phase)
byte_i  in  8  input byte
byte_valid_i  in  1  byte_i valid
byte_last_i  in  1  byte_i is the last byte of the current segment
seg_empty_i  in  1  with byte_valid_i: current segment has zero bytes; byte_i is ignored
byte_ready_o  out  1  packer accepts a byte this cycle
core_done_i  in  1  one-cycle strobe from the core: ready for the next block
block_o  out  128  packed block; byte k occupies bits [8k+7:8k]
block_valid_o  out  1  one-cycle pulse; block_o is valid
block_type_o  out  1  0 = AD, 1 = PT
block_last_o  out  1  final block of the segment (padded)
busy_o  out  1  message in progress

Behaviour:
- Reset: all outputs are 0, state is IDLE, credit=0, byte count=0, phase=AD. Reset mid-message discards all state with no partial emission.
- IDLE:
  - byte_ready_o=0.
  - start_i moves to FILL with phase=AD, busy_o=1, credit=0.
  - start_i received in any other state is ignored.
- FILL:
  - byte_ready_o=1.
  - An accepted byte is written at index cnt, then cnt increments.
  - If cnt reaches 16 and byte_last_i=0: go to HOLD with last=0.
  - If byte_last_i=1 and the new cnt<16: write 0x01 at index cnt, zero the upper bytes, last=1, go to HOLD.
  - If byte_last_i=1 and the new cnt=16: go to HOLD with last=0 and set pad_pending.
  - seg_empty_i in the AD phase: no block is emitted; phase becomes PT; stay in FILL.
  - seg_empty_i in the PT phase: build block 128'h01 with last=1, go to HOLD.
- HOLD:
  - byte_ready_o=0.
  - When credit=1: assert block_valid_o for exactly one cycle, clear credit, clear the buffer and cnt.
  - The earliest emission is the cycle after the completing byte is accepted.
- After emission:
  - pad_pending set: build 128'h01 with last=1, clear pad_pending, stay in HOLD.
  - last=1 and phase=AD: phase becomes PT, go to FILL.
  - last=1 and phase=PT: go to IDLE, busy_o=0.
  - Otherwise: go to FILL.
- Credit:
  - core_done_i sets credit, in any state except IDLE.
  - core_done_i arriving in the same cycle as an emission leaves credit=1.
  - Multiple strobes without an emission saturate credit at 1.
- block_o, block_type_o and block_last_o hold their values from emission until the next emission.

Optional Feature:
ASCON_PACKER_STATS_EN
- Defined: adds outputs ad_len_o[31:0] and pt_len_o[31:0].
  - Each counts bytes accepted per segment.
  - Cleared on start_i and on reset.
  - Saturate at 32'hFFFFFFFF.
- Undefined: these ports and counters do not exist.

Decomposition:
- Additions to ascon_pack:
  - seg_type_e {SEG_AD=0, SEG_PT=1}
  - packer_state_e {IDLE, FILL, HOLD}
  - PAD_BYTE_C=8'h01
  - BLOCK_BYTES_C=16
- Sub-module ascon_byte_buffer: byte-indexed 128-bit register with write, clear and pad-insert operations.
- The FSM and credit logic stay in the top module.

Test Plan:
- AD: start, credit, then "Alice to Bob" (12 bytes, last on byte 12) -> one pulse, block_o=128'h00000001626F42206F74206563696C41, type=0, last=1.
- PT: 47 bytes "Quevedeir..." with a credit after each emission -> 3 pulses:
  - block 1 = 128'h704F2065726964207475657620657551, last=0
  - block 3 = 128'h013F206172656E754D20746E75696E65, last=1
  - busy_o falls after block 3.
- PT of exactly 16 bytes -> full block with last=0, then (after a credit) 128'h01 with last=1.
- Credit gating: complete a block with credit=0 -> no pulse, byte_ready_o=0 for 10 cycles; core_done_i -> pulse on the next cycle.
- Empty AD via seg_empty_i -> no AD pulse; the next PT block has type=1. Empty PT -> single block 128'h01, last=1.
- reset_i high while 7 bytes are buffered -> next cycle all outputs are 0; a new start with AD "Alice to Bob" gives the correct block with no stale bytes.

Source files
------------

// File: rtl/ascon_pack.sv
// ascon_pack: shared types and constants for the ASCON-AEAD128 block packer.
//   seg_type_e     - segment kind carried with each block (AD or PT)
//   packer_state_e - packer FSM states
//   PAD_BYTE_C     - first byte of the 10* padding
//   BLOCK_BYTES_C  - bytes per AEAD128 rate block
package ascon_pack;

  localparam int unsigned BLOCK_BYTES_C = 16;
  localparam logic [7:0]  PAD_BYTE_C    = 8'h01;

  typedef enum logic {
    SEG_AD = 1'b0,
    SEG_PT = 1'b1
  } seg_type_e;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    HOLD
  } packer_state_e;

endpackage

// File: rtl/ascon_byte_buffer.sv
// ascon_byte_buffer: byte-indexed block register used by the packer.
// Ports:
//   clock_i, reset_i  - clock and synchronous active-high reset
//   clear_i           - zero the block and the byte count
//   load_pad_i        - load a pad-only block (PAD_BYTE_C in byte 0); wins over clear_i
//   wr_en_i           - write wr_byte_i at index cnt_o and advance the count
//   wr_byte_i         - byte to write
//   pad_after_i       - with wr_en_i: put PAD_BYTE_C right after the written byte and
//                       zero every byte above it
//   data_o            - block contents, byte k at bits [8k+7:8k]
//   cnt_o             - number of bytes written since the last clear
module ascon_byte_buffer
  import ascon_pack::*;
#(
  parameter int unsigned BLOCK_BYTES = BLOCK_BYTES_C
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic                           clear_i,
  input  logic                           load_pad_i,
  input  logic                           wr_en_i,
  input  logic [7:0]                     wr_byte_i,
  input  logic                           pad_after_i,
  output logic [8*BLOCK_BYTES-1:0]       data_o,
  output logic [$clog2(BLOCK_BYTES):0]   cnt_o
);

  localparam int unsigned IdxW = $clog2(BLOCK_BYTES);
  localparam int unsigned CntW = IdxW + 1;

  logic [8*BLOCK_BYTES-1:0] r_data;
  logic [8*BLOCK_BYTES-1:0] w_data_d;
  logic [CntW-1:0]          r_cnt;
  logic [CntW-1:0]          w_cnt_d;
  logic [IdxW-1:0]          w_idx;

  // Writes only happen while cnt < BLOCK_BYTES, so the low bits address the byte.
  assign w_idx = r_cnt[IdxW-1:0];

  always_comb begin
    w_data_d = r_data;
    w_cnt_d  = r_cnt;
    if (load_pad_i) begin
      w_data_d      = '0;
      w_data_d[7:0] = PAD_BYTE_C;
      w_cnt_d       = '0;
    end else if (clear_i) begin
      w_data_d = '0;
      w_cnt_d  = '0;
    end else if (wr_en_i) begin
      w_data_d[w_idx*8 +: 8] = wr_byte_i;
      w_cnt_d                = r_cnt + CntW'(1);
      if (pad_after_i) begin
        for (int k = 0; k < int'(BLOCK_BYTES); k++) begin
          if (k == int'(r_cnt) + 1) begin
            w_data_d[k*8 +: 8] = PAD_BYTE_C;
          end else if (k > int'(r_cnt) + 1) begin
            w_data_d[k*8 +: 8] = 8'h00;
          end
        end
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_data <= '0;
      r_cnt  <= '0;
    end else begin
      r_data <= w_data_d;
      r_cnt  <= w_cnt_d;
    end
  end

  assign data_o = r_data;
  assign cnt_o  = r_cnt;

endmodule

// File: rtl/ascon_block_packer.sv
// ascon_block_packer: packs an AD byte stream followed by a PT byte stream into
// 128-bit little-endian blocks with 10* padding on the last block of each segment,
// handing one block to the ASCON core per completion strobe.
// Ports:
//   clock_i, reset_i           - clock and synchronous active-high reset
//   start_i                    - begin a new message (honoured only when idle)
//   byte_i/byte_valid_i        - input byte stream
//   byte_last_i                - last byte of the current segment
//   seg_empty_i                - with byte_valid_i: current segment is empty
//   byte_ready_o               - a byte is accepted this cycle
//   core_done_i                - core strobe granting one block credit
//   block_o/block_valid_o      - packed block and its one-cycle valid
//   block_type_o               - 0 = AD, 1 = PT
//   block_last_o               - padded final block of the segment
//   busy_o                     - message in progress
//   ad_len_o/pt_len_o          - byte counts per segment (ASCON_PACKER_STATS_EN only)
// Optional feature macro: ASCON_PACKER_STATS_EN.
module ascon_block_packer
  import ascon_pack::*;
#(
  parameter int unsigned BLOCK_BYTES = BLOCK_BYTES_C
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  input  logic [7:0]               byte_i,
  input  logic                     byte_valid_i,
  input  logic                     byte_last_i,
  input  logic                     seg_empty_i,
  output logic                     byte_ready_o,
  input  logic                     core_done_i,
  output logic [8*BLOCK_BYTES-1:0] block_o,
  output logic                     block_valid_o,
  output logic                     block_type_o,
  output logic                     block_last_o,
  output logic                     busy_o
`ifdef ASCON_PACKER_STATS_EN
  ,
  output logic [31:0]              ad_len_o,
  output logic [31:0]              pt_len_o
`endif
);

  localparam int unsigned CntW = $clog2(BLOCK_BYTES) + 1;

  packer_state_e            r_state, w_state_d;
  seg_type_e                r_phase, w_phase_d;
  logic                     r_credit, w_credit_d;
  logic                     r_last, w_last_d;
  logic                     r_pad_pending, w_pad_pending_d;
  logic [8*BLOCK_BYTES-1:0] r_block;
  logic                     r_block_type;
  logic                     r_block_last;

  logic                     w_emit;
  logic                     w_cnt_full;
  logic                     w_buf_clear;
  logic                     w_buf_load_pad;
  logic                     w_buf_wr;
  logic                     w_buf_pad_after;
  logic [8*BLOCK_BYTES-1:0] w_buf_data;
  logic [CntW-1:0]          w_buf_cnt;

  ascon_byte_buffer #(
    .BLOCK_BYTES (BLOCK_BYTES)
  ) u_buffer (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .clear_i     (w_buf_clear),
    .load_pad_i  (w_buf_load_pad),
    .wr_en_i     (w_buf_wr),
    .wr_byte_i   (byte_i),
    .pad_after_i (w_buf_pad_after),
    .data_o      (w_buf_data),
    .cnt_o       (w_buf_cnt)
  );

  assign w_emit     = (r_state == HOLD) && r_credit;
  // The byte being accepted now fills the last slot.
  assign w_cnt_full = (w_buf_cnt == CntW'(BLOCK_BYTES - 1));

  always_comb begin
    w_state_d       = r_state;
    w_phase_d       = r_phase;
    w_last_d        = r_last;
    w_pad_pending_d = r_pad_pending;
    w_buf_clear     = 1'b0;
    w_buf_load_pad  = 1'b0;
    w_buf_wr        = 1'b0;
    w_buf_pad_after = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start_i) begin
          w_state_d       = FILL;
          w_phase_d       = SEG_AD;
          w_last_d        = 1'b0;
          w_pad_pending_d = 1'b0;
          w_buf_clear     = 1'b1;
        end
      end
      FILL: begin
        if (byte_valid_i) begin
          if (seg_empty_i) begin
            if (r_phase == SEG_AD) begin
              w_phase_d = SEG_PT;
            end else begin
              w_buf_load_pad = 1'b1;
              w_last_d       = 1'b1;
              w_state_d      = HOLD;
            end
          end else begin
            w_buf_wr = 1'b1;
            if (byte_last_i) begin
              w_state_d = HOLD;
              if (w_cnt_full) begin
                // Segment ends exactly on a block boundary: padding goes in its own block.
                w_last_d        = 1'b0;
                w_pad_pending_d = 1'b1;
              end else begin
                w_buf_pad_after = 1'b1;
                w_last_d        = 1'b1;
              end
            end else if (w_cnt_full) begin
              w_state_d = HOLD;
              w_last_d  = 1'b0;
            end
          end
        end
      end
      HOLD: begin
        if (w_emit) begin
          w_buf_clear = 1'b1;
          if (r_pad_pending) begin
            w_buf_load_pad  = 1'b1;
            w_last_d        = 1'b1;
            w_pad_pending_d = 1'b0;
          end else if (r_last) begin
            w_last_d = 1'b0;
            if (r_phase == SEG_AD) begin
              w_phase_d = SEG_PT;
              w_state_d = FILL;
            end else begin
              w_state_d = IDLE;
            end
          end else begin
            w_state_d = FILL;
          end
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  // An emission consumes the credit, but a strobe in the same cycle replaces it.
  always_comb begin
    w_credit_d = r_credit;
    if (w_emit) begin
      w_credit_d = core_done_i;
    end else if (core_done_i) begin
      w_credit_d = 1'b1;
    end
    if (r_state == IDLE || w_state_d == IDLE) begin
      w_credit_d = 1'b0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state       <= IDLE;
      r_phase       <= SEG_AD;
      r_credit      <= 1'b0;
      r_last        <= 1'b0;
      r_pad_pending <= 1'b0;
      r_block       <= '0;
      r_block_type  <= 1'b0;
      r_block_last  <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_phase       <= w_phase_d;
      r_credit      <= w_credit_d;
      r_last        <= w_last_d;
      r_pad_pending <= w_pad_pending_d;
      if (w_emit) begin
        r_block      <= w_buf_data;
        r_block_type <= r_phase;
        r_block_last <= r_last;
      end
    end
  end

  // The emitted block is presented straight from the buffer and then held in r_block,
  // so it stays visible while the buffer is refilled.
  assign block_valid_o = w_emit;
  assign block_o       = w_emit ? w_buf_data : r_block;
  assign block_type_o  = w_emit ? r_phase    : r_block_type;
  assign block_last_o  = w_emit ? r_last     : r_block_last;
  assign byte_ready_o  = (r_state == FILL);
  assign busy_o        = (r_state != IDLE);

`ifdef ASCON_PACKER_STATS_EN
  logic [31:0] r_ad_len;
  logic [31:0] r_pt_len;
  logic        w_count_byte;

  assign w_count_byte = (r_state == FILL) && byte_valid_i && !seg_empty_i;

  always_ff @(posedge clock_i) begin
    if (reset_i || (r_state == IDLE && start_i)) begin
      r_ad_len <= '0;
      r_pt_len <= '0;
    end else if (w_count_byte) begin
      if (r_phase == SEG_AD) begin
        if (r_ad_len != 32'hFFFF_FFFF) r_ad_len <= r_ad_len + 32'd1;
      end else begin
        if (r_pt_len != 32'hFFFF_FFFF) r_pt_len <= r_pt_len + 32'd1;
      end
    end
  end

  assign ad_len_o = r_ad_len;
  assign pt_len_o = r_pt_len;
`endif

endmodule
